pong_anim_graph: RTL
====================

PONG_ANIM_GRAPH -- requirements
Module: pong_anim_graph

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in lines
- WALL_XL, 32, left wall first column
- WALL_XR, 35, left wall last column
- BAR_XL, 600, paddle first column
- BAR_XR, 603, paddle last column
- BAR_H, 72, paddle height in lines
- BAR_V, 4, paddle step per frame
- BALL_SZ, 8, ball square side
- BALL_V, 2, ball step per frame per axis
- SERVE_FRAMES, 60, frames held in SERVE
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, single system clock
- reset, in, 1, synchronous, active-high
- video_on, in, 1, visible-area flag from the sync generator
- pix_x, in, 10, current pixel column
- pix_y, in, 10, current pixel line
- btn_up, in, 1, paddle-up request, level
- btn_down, in, 1, paddle-down request, level
- rgb, out, 12, registered pixel colour
- frame_tick, out, 1, one-cycle frame pulse
- game_state, out, 2, 0=SERVE, 1=PLAY, 2=MISS
- hit_cnt, out, 8, paddle hits
- miss_cnt, out, 4, misses
REQ-003 One clock domain only. Reset is synchronous and active-high. All state updates occur on the rising clock edge.

Function
REQ-004 frame_tick is 1 for exactly one cycle when pix_x==0 and pix_y==V_RES; it is 0 otherwise.
REQ-005 Ball, paddle, direction, state and counter registers change only in the cycle where frame_tick is 1.
REQ-006 Rendering: rgb is registered with one-cycle latency from pix_x/pix_y, using the current position registers.
- Priority: wall 12'h00F > paddle 12'h0F0 > ball 12'hF00 > background 12'h000.
- rgb is 12'h000 whenever video_on is 0.
REQ-007 Wall region: WALL_XL<=pix_x<=WALL_XR, all lines. Paddle region: BAR_XL<=pix_x<=BAR_XR and bar_y<=pix_y<=bar_y+BAR_H-1.
REQ-008 Ball region: ball_x<=pix_x<=ball_x+BALL_SZ-1 and ball_y<=pix_y<=ball_y+BALL_SZ-1.
REQ-009 Paddle movement on each tick, in every state:
- btn_up and bar_y>=BAR_V: bar_y -= BAR_V.
- btn_down and bar_y+BAR_H-1+BAR_V<=V_RES-1: bar_y += BAR_V.
- Both buttons high: no movement.
- A move that would cross a screen edge: no movement; the paddle is not clamped.
REQ-010 PLAY direction update on a tick, evaluated in this order (later rules override earlier):
- ball_y<=BALL_V: dy=+.
- ball_y+BALL_SZ-1>=V_RES-1-BALL_V: dy=-.
- ball_x<=WALL_XR+1: dx=+.
- Ball right edge in [BAR_XL,BAR_XR] and ball vertically overlapping the paddle: dx=-; hit_cnt increments, wrapping 255->0.
REQ-011 PLAY miss: if ball_x > BAR_XR, go to MISS and leave the ball frozen this tick; miss_cnt increments and saturates at 15. Otherwise the position moves by ±BALL_V per axis, using the directions just updated.
REQ-012 MISS lasts exactly one tick, then goes to SERVE. On the MISS->SERVE transition: ball returns to (H_RES/2, V_RES/2), dx=+, dy=+, serve counter cleared.
REQ-013 SERVE: the ball is shown stationary; the serve counter increments each tick. When the counter reaches SERVE_FRAMES-1, go to PLAY on that tick.
REQ-014 Widths: position arithmetic is 10-bit unsigned. Bounce tests (REQ-010) are applied before any step, so no position ever underflows or exceeds H_RES/V_RES.

Reset
REQ-015 While reset is 1, on each clock edge:
- rgb=0, frame_tick=0, state=SERVE, hit_cnt=0, miss_cnt=0, serve counter=0.
- ball=(H_RES/2, V_RES/2), dx=+, dy=+.
- bar_y=(V_RES-BAR_H)/2, i.e. 204.
REQ-016 Reset asserted mid-frame or mid-state overrides every pending update on that edge. The first tick after release is treated as a normal SERVE tick.

Verification
REQ-017 Reset, then a raster at defaults: pixel (33,100) -> rgb 00F; (601,204) and (601,275) -> 0F0; (601,276) -> 000; (322,242) -> F00; video_on=0 -> 000.
REQ-018 SERVE timing: with no buttons, game_state reads 0 for 60 ticks and 1 after the 60th. On the next PLAY tick the ball is at (322,242).
REQ-019 Paddle: btn_up held for 51 ticks -> bar_y=0 and stays 0. Both buttons held -> bar_y unchanged.
REQ-020 Paddle hit: bar_y placed to overlap the ball path -> dx reverses on the tick where the ball right edge reaches 600..603, hit_cnt=1. Wall bounce at ball_x<=36 -> dx=+.
REQ-021 Miss: paddle held at top while the ball approaches at y≈240 -> MISS for one tick, miss_cnt=1, then SERVE with the ball at (320,240). 16 misses -> miss_cnt=15.
REQ-022 Reset pulsed during PLAY mid-frame -> all REQ-015 values restored on the next edge.

Source files
------------

// File: rtl/pong_anim_graph.sv
// Pong frame logic: ball, paddle and score state advance once per frame tick,
// and a registered pixel colour is produced from the current positions.
module pong_anim_graph #(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned WALL_XL      = 32,
    parameter int unsigned WALL_XR      = 35,
    parameter int unsigned BAR_XL       = 600,
    parameter int unsigned BAR_XR       = 603,
    parameter int unsigned BAR_H        = 72,
    parameter int unsigned BAR_V        = 4,
    parameter int unsigned BALL_SZ      = 8,
    parameter int unsigned BALL_V       = 2,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [1:0]  game_state,
    output logic [7:0]  hit_cnt,
    output logic [3:0]  miss_cnt
);

    localparam int unsigned SerW = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0] VRes     = 10'(V_RES);
    localparam logic [9:0] VMax     = 10'(V_RES - 1);
    localparam logic [9:0] WallXl   = 10'(WALL_XL);
    localparam logic [9:0] WallXr   = 10'(WALL_XR);
    localparam logic [9:0] BarXl    = 10'(BAR_XL);
    localparam logic [9:0] BarXr    = 10'(BAR_XR);
    localparam logic [9:0] BarHM1   = 10'(BAR_H - 1);
    localparam logic [9:0] BarV     = 10'(BAR_V);
    localparam logic [9:0] BallSzM1 = 10'(BALL_SZ - 1);
    localparam logic [9:0] BallV    = 10'(BALL_V);
    localparam logic [9:0] BallX0   = 10'(H_RES / 2);
    localparam logic [9:0] BallY0   = 10'(V_RES / 2);
    localparam logic [9:0] BarY0    = 10'((V_RES - BAR_H) / 2);

    localparam logic [SerW-1:0] SerLast = SerW'(SERVE_FRAMES - 1);

    localparam logic [11:0] ColWall = 12'h00F;
    localparam logic [11:0] ColBar  = 12'h0F0;
    localparam logic [11:0] ColBall = 12'hF00;
    localparam logic [11:0] ColBg   = 12'h000;

    typedef enum logic [1:0] {
        StServe = 2'd0,
        StPlay  = 2'd1,
        StMiss  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      ball_x_q, ball_x_d;
    logic [9:0]      ball_y_q, ball_y_d;
    logic [9:0]      bar_y_q, bar_y_d;
    logic            dx_q, dx_d;
    logic            dy_q, dy_d;
    logic [7:0]      hit_q, hit_d;
    logic [3:0]      miss_q, miss_d;
    logic [SerW-1:0] serve_q, serve_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            tick_cond, tick_cond_q, tick_q;

    // Geometry derived from the current position registers.
    logic [9:0] ball_r, ball_b, bar_b;
    logic       bar_up_ok, bar_dn_ok;
    logic       hit_top, hit_bot, hit_wall, hit_bar, missed;
    logic       wall_on, bar_on, ball_on;
    logic       dx_n, dy_n;

    assign ball_r = ball_x_q + BallSzM1;
    assign ball_b = ball_y_q + BallSzM1;
    assign bar_b  = bar_y_q + BarHM1;

    assign bar_up_ok = bar_y_q >= BarV;
    assign bar_dn_ok = (bar_y_q + BarHM1 + BarV) <= VMax;

    assign hit_top  = ball_y_q <= BallV;
    assign hit_bot  = ball_b >= (VMax - BallV);
    assign hit_wall = ball_x_q <= (WallXr + 10'd1);
    assign hit_bar  = (ball_r >= BarXl) && (ball_r <= BarXr) &&
                      (ball_b >= bar_y_q) && (ball_y_q <= bar_b);
    assign missed   = ball_x_q > BarXr;

    assign wall_on = (pix_x >= WallXl) && (pix_x <= WallXr);
    assign bar_on  = (pix_x >= BarXl) && (pix_x <= BarXr) &&
                     (pix_y >= bar_y_q) && (pix_y <= bar_b);
    assign ball_on = (pix_x >= ball_x_q) && (pix_x <= ball_r) &&
                     (pix_y >= ball_y_q) && (pix_y <= ball_b);

    // Edge-detect the frame position so a held pixel still yields a single pulse.
    assign tick_cond = (pix_x == 10'd0) && (pix_y == VRes);

    always_comb begin
        rgb_d = ColBg;
        if (video_on) begin
            if (wall_on) begin
                rgb_d = ColWall;
            end else if (bar_on) begin
                rgb_d = ColBar;
            end else if (ball_on) begin
                rgb_d = ColBall;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        bar_y_d  = bar_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        serve_d  = serve_q;
        dx_n     = dx_q;
        dy_n     = dy_q;

        if (tick_q) begin
            if (btn_up && !btn_down && bar_up_ok) begin
                bar_y_d = bar_y_q - BarV;
            end else if (btn_down && !btn_up && bar_dn_ok) begin
                bar_y_d = bar_y_q + BarV;
            end

            unique case (state_q)
                StServe: begin
                    serve_d = serve_q + 1'b1;
                    if (serve_q == SerLast) begin
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    // Later bounce rules override earlier ones.
                    if (hit_top) dy_n = 1'b1;
                    if (hit_bot) dy_n = 1'b0;
                    if (hit_wall) dx_n = 1'b1;
                    if (hit_bar) begin
                        dx_n  = 1'b0;
                        hit_d = hit_q + 8'd1;
                    end
                    dx_d = dx_n;
                    dy_d = dy_n;
                    if (missed) begin
                        state_d = StMiss;
                        if (miss_q != 4'hF) miss_d = miss_q + 4'd1;
                    end else begin
                        ball_x_d = dx_n ? (ball_x_q + BallV) : (ball_x_q - BallV);
                        ball_y_d = dy_n ? (ball_y_q + BallV) : (ball_y_q - BallV);
                    end
                end
                StMiss: begin
                    state_d  = StServe;
                    ball_x_d = BallX0;
                    ball_y_d = BallY0;
                    dx_d     = 1'b1;
                    dy_d     = 1'b1;
                    serve_d  = '0;
                end
                default: begin
                    state_d = StServe;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StServe;
            ball_x_q    <= BallX0;
            ball_y_q    <= BallY0;
            bar_y_q     <= BarY0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            hit_q       <= 8'd0;
            miss_q      <= 4'd0;
            serve_q     <= '0;
            rgb_q       <= 12'h000;
            tick_cond_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            bar_y_q     <= bar_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            serve_q     <= serve_d;
            rgb_q       <= rgb_d;
            tick_cond_q <= tick_cond;
            tick_q      <= tick_cond & ~tick_cond_q;
        end
    end

    assign rgb        = rgb_q;
    assign frame_tick = tick_q;
    assign game_state = state_q;
    assign hit_cnt    = hit_q;
    assign miss_cnt   = miss_q;

endmodule
